serial_subtractor_23bit: RTL and testbench
==========================================

Name: serial_subtractor_23bit

Overview:
Bit-serial two's-complement subtractor, the inverse-direction companion to the team's combinational 23-bit adder. It computes diff = a - b one bit per clock, LSB first, using a single full-adder cell with b inverted and initial carry-in 1. It sits in the sample-processing path where area matters more than latency, for example delta and error terms between 23-bit mic-channel samples. Valid/ready handshakes are used on both the input and output sides.

Parameters:
WIDTH, 23, operand and result width in bits (two's complement); must be >= 2.
CNT_W, 5, width of the bit counter; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operands a/b are presented.
in_ready  output  1  block can accept operands (IDLE only).
a  input  WIDTH  minuend, two's complement.
b  input  WIDTH  subtrahend, two's complement.
out_valid  output  1  diff/borrow_out/overflow are valid.
out_ready  input  1  consumer accepts the result.
diff  output  WIDTH  a - b modulo 2**WIDTH.
borrow_out  output  1  unsigned borrow: 1 iff unsigned(a) < unsigned(b), i.e. NOT of the final carry.
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (async, any state): state=IDLE; diff=0, borrow_out=0, overflow=0, out_valid=0, busy=0, count=0, carry=0. in_ready=1 immediately after reset asserts (combinational from state).
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid & in_ready: capture a into sh_a and ~b into sh_b; set carry=1, count=0; go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - Each edge: s = sh_a[0] ^ sh_b[0] ^ carry; carry <= majority(sh_a[0], sh_b[0], carry).
  - sh_a and sh_b shift right by one; s shifts into the MSB of the result register (so after WIDTH shifts, bit0 lands at diff[0]).
  - On the edge processing bit WIDTH-1, also latch msb_cin = carry (the carry before update).
  - When count==WIDTH-1 on an edge: go to DONE; set out_valid=1, borrow_out=~carry_next, overflow=msb_cin ^ carry_next.
- Latency: accept at edge E0; out_valid rises after edge E0+WIDTH (23 clocks for the default).
- DONE:
  - out_valid=1; diff/borrow_out/overflow held stable.
  - On an edge with out_ready=1: go to IDLE, out_valid=0. Outputs keep their last value.
  - in_ready=0, so back-to-back acceptance cannot occur in the same cycle. Minimum issue interval is WIDTH+2 clocks.
- in_valid while busy: ignored, no capture. a/b may change freely after acceptance.
- out_ready while not DONE: ignored.
- Width rules:
  - The result wraps modulo 2**WIDTH.
  - Signed a-b where a=-2**(WIDTH-1) and b>0, or a>=0 and b<0 with out-of-range result, sets overflow.
  - The diff bits are always the wrapped value.
- Mid-operation reset: any partial result is discarded and no out_valid is produced. The first operation after reset deassertion behaves identically to a post-power-up operation.

Decomposition:
- Shared package sub_pkg: WIDTH_DEF=23, CNT_W_DEF=5, and the state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2). The package is reused by the adder test and the future serial adder.
- One natural sub-module: sub_bit_cell (combinational full adder: x, y, cin -> s, cout), instanced once in the datapath.
- FSM, counter and shift registers live in the top.

Test Plan:
1. a=0x000001, b=0x000001 -> diff=0x000000, borrow_out=0, overflow=0; out_valid high exactly 23 clocks after acceptance.
2. a=0x000000, b=0x000001 -> diff=0x7FFFFF (-1), borrow_out=1, overflow=0.
3. a=0x400000 (-4194304), b=0x000001 -> diff=0x3FFFFF, overflow=1, borrow_out=0.
4. a=0x3FFFFF, b=0x7FFFFF (-1) -> diff=0x400000, overflow=1, borrow_out=1.
5. Backpressure and ignored input:
   - Hold out_ready=0 for 5 cycles after out_valid. Result and out_valid must stay stable and in_ready must stay 0; in_valid pulses during this time are not captured.
   - Then assert out_ready for 1 cycle: the next cycle is IDLE with in_ready=1.
6. Reset mid-operation:
   - Assert rst asynchronously at SHIFT count=10. All outputs go to 0 and in_ready goes to 1 without waiting for a clock edge.
   - After release, a=0x2AAAAA, b=0x155555 gives diff=0x155555, borrow_out=0, overflow=0.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared constants and FSM state encoding for the serial arithmetic blocks.
// Reused by the serial subtractor, the adder test and the future serial adder.
package sub_pkg;

  localparam int WIDTH_DEF = 23;
  localparam int CNT_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sub_bit_cell.sv
// Single-bit full adder cell used as the serial datapath.
// Subtraction comes from feeding it ~b with an initial carry of 1.
module sub_bit_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_subtractor_23bit.sv
// Bit-serial two's-complement subtractor, diff = a - b, LSB first.
// One bit per clock through a single full-adder cell; valid/ready on both sides.
module serial_subtractor_23bit
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CNT_W-1:0] count;
  logic             carry;
  logic             s;
  logic             carry_next;
  logic             last;

  sub_bit_cell u_cell (
    .x    (sh_a[0]),
    .y    (sh_b[0]),
    .cin  (carry),
    .s    (s),
    .cout (carry_next)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign last     = (count == CNT_W'(WIDTH - 1));

  // carry still holds the carry into the MSB on the last shift edge,
  // so overflow is formed directly from carry and carry_next there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sh_a       <= '0;
      sh_b       <= '0;
      count      <= '0;
      carry      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh_a  <= a;
            sh_b  <= ~b;
            carry <= 1'b1;
            count <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          diff  <= {s, diff[WIDTH-1:1]};
          carry <= carry_next;
          count <= count + CNT_W'(1);
          if (last) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            borrow_out <= ~carry_next;
            overflow   <= carry ^ carry_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_23bit.sv
// Directed self-checking bench for serial_subtractor_23bit.
// Expected values are hand-computed 23-bit two's-complement results.
module tb_serial_subtractor_23bit;

  localparam int W = 23;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;
  logic         busy;

  int checks = 0;
  int errors = 0;

  serial_subtractor_23bit dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one operand pair, wait for out_valid, check latency and result.
  task automatic do_op(input string tag, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic [W-1:0] ed,
                       input logic eb, input logic eo);
    int n;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = ~va;
    b        = ~vb;
    n        = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd23);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_borrow"}, 32'(borrow_out), 32'(eb));
    check({tag, "_ovf"}, 32'(overflow), 32'(eo));
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] held;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #1;
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_op("t1", 23'h000001, 23'h000001, 23'h000000, 1'b0, 1'b0);
    drain("t1");
    do_op("t2", 23'h000000, 23'h000001, 23'h7FFFFF, 1'b1, 1'b0);
    drain("t2");
    do_op("t3", 23'h400000, 23'h000001, 23'h3FFFFF, 1'b0, 1'b1);
    drain("t3");
    do_op("t4", 23'h3FFFFF, 23'h7FFFFF, 23'h400000, 1'b1, 1'b1);

    // Backpressure: hold the result while in_valid pulses are ignored.
    held = diff;
    for (int i = 0; i < 5; i++) begin
      a        = 23'h123456;
      b        = 23'h000042;
      in_valid = i[0];
      @(posedge clk);
      #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_diff", 32'(diff), 32'(held));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    drain("t5");
    check("t5_hold_diff", 32'(diff), 32'h400000);
    check("t5_hold_borrow", 32'(borrow_out), 32'd1);

    // Reset asynchronously partway through a shift (count=10).
    a        = 23'h000005;
    b        = 23'h000003;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    check("t6_pre_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_diff", 32'(diff), 32'd0);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd1);
    check("t6_rst_ovf", 32'(overflow), 32'd0);
    check("t6_rst_borrow", 32'(borrow_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_op("t6", 23'h2AAAAA, 23'h155555, 23'h155555, 1'b0, 1'b0);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
